// File: rtl/cpu_debug_ocimem_sequencer.sv
// Debug-host OCI memory sequencer: turns decoded JTAG action strobes into
// single-word reads/writes on a waitrequest memory port, with stall timeout,
// and reports the read data and completion/error status back to the host.
module cpu_debug_ocimem_sequencer #(
  parameter int AW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  output logic [AW-1:0] mem_address,
  output logic          mem_read,
  output logic          mem_write,
  output logic [31:0]   mem_writedata,
  input  logic [31:0]   mem_readdata,
  input  logic          mem_waitrequest,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   mon_q, mon_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;
  logic          pend_q, pend_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          rd_q, wr_q, busy_q;
  logic          any_strobe;

  // Only the address field, read flag and write data of jdo are meaningful;
  // the remaining bits are deliberately ignored.
  logic          unused_jdo;
  assign unused_jdo = ^jdo;

  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a |
                      take_action_ocimem_b;

  // Next-state and next-value logic for the command sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mon_d   = mon_q;
    ready_d = ready_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    pend_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // An address-only load reports ready one cycle after acceptance.
        if (pend_q) ready_d = 1'b1;
        if (any_strobe) begin
          ready_d = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
        if (take_action_ocimem_b) begin
          wdata_d = jdo[34:3];
          state_d = WR;
        end else if (take_action_ocimem_a) begin
          addr_d = jdo[AW+1:2];
          if (jdo[35]) state_d = RD;
          else         pend_d  = 1'b1;
        end else if (take_no_action_ocimem_a) begin
          state_d = RD;
        end
      end
      RD, WR: begin
        // Host commands cannot be queued; flag the loss but finish the access.
        if (any_strobe) err_d = 1'b1;
        if (!mem_waitrequest) begin
          if (state_q == RD) mon_d = mem_readdata;
          addr_d  = addr_q + 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == 16'(TIMEOUT)) begin
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; request strobes are flopped from the next state
  // so every port is driven straight from a register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mon_q   <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mon_q   <= mon_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      rd_q    <= (state_d == RD);
      wr_q    <= (state_d == WR);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign mem_address   = addr_q;
  assign mem_read      = rd_q;
  assign mem_write     = wr_q;
  assign mem_writedata = wdata_q;
  assign MonDReg       = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_cpu_debug_ocimem_sequencer.sv
// Self-checking bench for cpu_debug_ocimem_sequencer (AW=8, TIMEOUT=4).
module tb_cpu_debug_ocimem_sequencer;
  localparam int AW = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [37:0]   jdo;
  logic          sa, sna, sb;
  logic [AW-1:0] mem_address;
  logic          mem_read, mem_write;
  logic [31:0]   mem_writedata;
  logic [31:0]   mem_readdata;
  logic          mem_waitrequest;
  logic [31:0]   MonDReg;
  logic          monitor_ready, monitor_error, busy;

  cpu_debug_ocimem_sequencer #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(sa), .take_no_action_ocimem_a(sna),
    .take_action_ocimem_b(sb),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state
  logic [AW-1:0] m_addr;
  logic [31:0]   m_mon;

  // Observations of the last command
  int            hold;
  bit            stable, saw_rd, saw_wr;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wd;

  function automatic logic [37:0] mk_a(input bit rd, input logic [AW-1:0] ad);
    logic [37:0] j;
    j = 38'({$urandom(), $urandom()});
    j[35] = rd;
    j[AW+1:2] = ad;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = 38'({$urandom(), $urandom()});
    j[34:3] = d;
    return j;
  endfunction

  // Issue strobes at the next edge and act as a slave stalling for 'waits'
  // cycles; returns after the request drops (or a 200-cycle bound expires).
  task automatic run_cmd(input bit a, input bit na, input bit b,
                         input logic [37:0] j, input int waits,
                         input logic [31:0] rdata);
    sa = a; sna = na; sb = b; jdo = j;
    mem_readdata = rdata;
    mem_waitrequest = (waits > 0);
    @(posedge clk); #1;
    sa = 1'b0; sna = 1'b0; sb = 1'b0;
    hold = 0; stable = 1'b1; saw_rd = 1'b0; saw_wr = 1'b0;
    req_addr = mem_address; req_wd = mem_writedata;
    while ((mem_read || mem_write) && hold < 200) begin
      hold++;
      if (mem_read)  saw_rd = 1'b1;
      if (mem_write) saw_wr = 1'b1;
      if (mem_address !== req_addr || mem_writedata !== req_wd) stable = 1'b0;
      mem_waitrequest = (hold <= waits);
      @(posedge clk); #1;
    end
    mem_waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sa = 0; sna = 0; sb = 0; jdo = '0;
    mem_readdata = '0; mem_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    m_addr = '0; m_mon = '0;
    total_cnt++; if ({mem_read, mem_write, busy} !== 3'b000)
      $display("FAIL reset_req got rd/wr/busy=%b want 000", {mem_read, mem_write, busy}); else pass_cnt++;
    total_cnt++; if (mem_address !== '0 || mem_writedata !== '0 || MonDReg !== '0)
      $display("FAIL reset_data got addr=%h wd=%h mon=%h want 0", mem_address, mem_writedata, MonDReg); else pass_cnt++;
    total_cnt++; if ({monitor_ready, monitor_error} !== 2'b10)
      $display("FAIL reset_status got rdy/err=%b want 10", {monitor_ready, monitor_error}); else pass_cnt++;
  endtask

  task automatic test_read_basic();
    run_cmd(1, 0, 0, mk_a(1, 8'h10), 0, 32'hDEADBEEF);
    total_cnt++; if (hold !== 1 || !saw_rd || saw_wr || req_addr !== 8'h10)
      $display("FAIL rd_basic_req got hold=%0d rd=%0b wr=%0b addr=%h want 1 1 0 10", hold, saw_rd, saw_wr, req_addr); else pass_cnt++;
    total_cnt++; if (MonDReg !== 32'hDEADBEEF)
      $display("FAIL rd_basic_mon got %h want deadbeef", MonDReg); else pass_cnt++;
    total_cnt++; if (mem_address !== 8'h11 || monitor_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL rd_basic_done got addr=%h rdy=%b busy=%b want 11 1 0", mem_address, monitor_ready, busy); else pass_cnt++;
    m_addr = 8'h11; m_mon = 32'hDEADBEEF;
  endtask

  task automatic test_write_wrap();
    run_cmd(1, 0, 0, mk_a(0, 8'hFF), 0, 32'h0);
    total_cnt++; if (hold !== 0 || mem_address !== 8'hFF || monitor_ready !== 1'b0)
      $display("FAIL load_addr got hold=%0d addr=%h rdy=%b want 0 ff 0", hold, mem_address, monitor_ready); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (monitor_ready !== 1'b1)
      $display("FAIL load_ready got %b want 1", monitor_ready); else pass_cnt++;
    run_cmd(0, 0, 1, mk_b(32'h12345678), 3, 32'h0);
    total_cnt++; if (hold !== 4 || !saw_wr || saw_rd || !stable || req_addr !== 8'hFF || req_wd !== 32'h12345678)
      $display("FAIL wr_wrap_req got hold=%0d wr=%0b stable=%0b addr=%h wd=%h want 4 1 1 ff 12345678", hold, saw_wr, stable, req_addr, req_wd); else pass_cnt++;
    total_cnt++; if (mem_address !== 8'h00 || monitor_ready !== 1'b1 || monitor_error !== 1'b0)
      $display("FAIL wr_wrap_done got addr=%h rdy=%b err=%b want 00 1 0", mem_address, monitor_ready, monitor_error); else pass_cnt++;
    m_addr = 8'h00;
  endtask

  task automatic test_no_action_pair();
    logic [31:0] d;
    run_cmd(1, 0, 0, mk_a(0, 8'h20), 0, 32'h0);
    @(posedge clk); #1;
    m_addr = 8'h20;
    for (int i = 0; i < 2; i++) begin
      d = $urandom();
      run_cmd(0, 1, 0, mk_a(1, 8'(~m_addr)), i, d);
      total_cnt++; if (hold !== i + 1 || !saw_rd || req_addr !== m_addr)
        $display("FAIL noact_req%0d got hold=%0d rd=%0b addr=%h want %0d 1 %h", i, hold, saw_rd, req_addr, i + 1, m_addr); else pass_cnt++;
      m_addr = m_addr + 1'b1; m_mon = d;
      total_cnt++; if (MonDReg !== m_mon || mem_address !== m_addr)
        $display("FAIL noact_res%0d got mon=%h addr=%h want %h %h", i, MonDReg, mem_address, m_mon, m_addr); else pass_cnt++;
    end
  endtask

  task automatic test_timeout();
    run_cmd(0, 1, 0, '0, 1000, 32'hA5A5A5A5);
    total_cnt++; if (hold !== TO + 1 || !saw_rd)
      $display("FAIL tmo_hold got %0d want %0d", hold, TO + 1); else pass_cnt++;
    total_cnt++; if (monitor_error !== 1'b1 || monitor_ready !== 1'b1 || mem_address !== m_addr || MonDReg !== m_mon)
      $display("FAIL tmo_status got err=%b rdy=%b addr=%h mon=%h want 1 1 %h %h", monitor_error, monitor_ready, mem_address, MonDReg, m_addr, m_mon); else pass_cnt++;
    run_cmd(0, 1, 0, '0, 1, 32'h0BADF00D);
    m_addr = m_addr + 1'b1; m_mon = 32'h0BADF00D;
    total_cnt++; if (monitor_error !== 1'b0 || MonDReg !== m_mon || mem_address !== m_addr)
      $display("FAIL tmo_clear got err=%b mon=%h addr=%h want 0 %h %h", monitor_error, MonDReg, mem_address, m_mon, m_addr); else pass_cnt++;
  endtask

  task automatic test_priority_busy();
    int cyc;
    sa = 1; sb = 1; sna = 0; jdo = mk_b(32'hCAFEF00D);
    mem_waitrequest = 1'b1;
    @(posedge clk); #1;
    sa = 0; sb = 0;
    total_cnt++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== m_addr || mem_writedata !== 32'hCAFEF00D)
      $display("FAIL prio_req got wr=%b rd=%b addr=%h wd=%h want 1 0 %h cafef00d", mem_write, mem_read, mem_address, mem_writedata, m_addr); else pass_cnt++;
    sna = 1;
    @(posedge clk); #1;
    sna = 0;
    mem_waitrequest = 1'b0;
    @(posedge clk); #1;
    m_addr = m_addr + 1'b1;
    total_cnt++; if (busy !== 1'b0 || monitor_error !== 1'b1 || monitor_ready !== 1'b1 || mem_address !== m_addr)
      $display("FAIL busy_drop got busy=%b err=%b rdy=%b addr=%h want 0 1 1 %h", busy, monitor_error, monitor_ready, mem_address, m_addr); else pass_cnt++;
    cyc = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (mem_read || mem_write) cyc++;
    end
    total_cnt++; if (cyc !== 0 || mem_address !== m_addr || monitor_error !== 1'b1)
      $display("FAIL busy_noexec got reqcycles=%0d addr=%h err=%b want 0 %h 1", cyc, mem_address, monitor_error, m_addr); else pass_cnt++;
  endtask

  task automatic test_random();
    bit a, na, b, rd;
    int waits, exp_hold;
    logic [31:0] d, rdata;
    logic [37:0] j;
    bit is_rd, is_wr, ok;
    for (int n = 0; n < 30; n++) begin
      {a, na, b} = 3'($urandom_range(1, 7));
      rd = 1'($urandom());
      d = $urandom(); rdata = $urandom();
      waits = $urandom_range(0, 6);
      j = b ? mk_b(d) : mk_a(rd, 8'($urandom()));
      is_rd = 0; is_wr = 0;
      if (b) is_wr = 1;
      else if (a) begin
        m_addr = j[AW+1:2];
        is_rd = j[35];
      end else is_rd = 1;
      run_cmd(a, na, b, j, waits, rdata);
      if (!is_rd && !is_wr) begin
        total_cnt++; if (hold !== 0 || mem_address !== m_addr || monitor_ready !== 1'b0)
          $display("FAIL rnd%0d_load got hold=%0d addr=%h rdy=%b want 0 %h 0", n, hold, mem_address, monitor_ready, m_addr); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (monitor_ready !== 1'b1 || monitor_error !== 1'b0)
          $display("FAIL rnd%0d_loadrdy got rdy=%b err=%b want 1 0", n, monitor_ready, monitor_error); else pass_cnt++;
      end else begin
        ok = (waits <= TO);
        exp_hold = ok ? waits + 1 : TO + 1;
        total_cnt++; if (hold !== exp_hold || saw_rd !== is_rd || saw_wr !== is_wr || req_addr !== m_addr || !stable || (is_wr && req_wd !== d))
          $display("FAIL rnd%0d_req got hold=%0d rd=%0b wr=%0b addr=%h stable=%0b wd=%h want %0d %0b %0b %h 1 %h", n, hold, saw_rd, saw_wr, req_addr, stable, req_wd, exp_hold, is_rd, is_wr, m_addr, d); else pass_cnt++;
        if (ok) begin
          if (is_rd) m_mon = rdata;
          m_addr = m_addr + 1'b1;
        end
        total_cnt++; if (mem_address !== m_addr || MonDReg !== m_mon || monitor_error !== !ok || monitor_ready !== 1'b1 || busy !== 1'b0)
          $display("FAIL rnd%0d_done got addr=%h mon=%h err=%b rdy=%b busy=%b want %h %h %b 1 0", n, mem_address, MonDReg, monitor_error, monitor_ready, busy, m_addr, m_mon, !ok); else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid();
    sa = 1; jdo = mk_a(1, 8'h42); mem_waitrequest = 1'b1;
    @(posedge clk); #1;
    sa = 0;
    @(posedge clk); #2;
    total_cnt++; if (mem_read !== 1'b1 || busy !== 1'b1)
      $display("FAIL rstmid_pre got rd=%b busy=%b want 1 1", mem_read, busy); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total_cnt++; if ({mem_read, mem_write, busy, monitor_ready, monitor_error} !== 5'b00010 || mem_address !== '0 || MonDReg !== '0 || mem_writedata !== '0)
      $display("FAIL rstmid_async got rd/wr/busy/rdy/err=%b addr=%h mon=%h wd=%h want 00010 0 0 0", {mem_read, mem_write, busy, monitor_ready, monitor_error}, mem_address, MonDReg, mem_writedata); else pass_cnt++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    mem_waitrequest = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (mem_read !== 1'b0 || busy !== 1'b0)
      $display("FAIL rstmid_after got rd=%b busy=%b want 0 0", mem_read, busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_wrap();
    test_no_action_pair();
    test_timeout();
    test_priority_busy();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
